// File: rtl/fixed_point_lane_dot.sv
// Multi-cycle signed fixed-point dot product of two N-element vectors, LANES multipliers per cycle.
// Build macro FIXED_POINT_LANE_DOT_SAT_EN clamps the result into P_WIDTH instead of wrapping.

module fixed_point_lane_dot_lane #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16
) (
    input  logic                       en,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic [A_WIDTH+B_WIDTH-1:0] prod
);
    logic signed [A_WIDTH+B_WIDTH-1:0] full;

    // Sign-extend both operands to the product width so the multiply is exact.
    assign full = $signed({{B_WIDTH{a[A_WIDTH-1]}}, a}) * $signed({{A_WIDTH{b[B_WIDTH-1]}}, b});
    assign prod = en ? full : '0;
endmodule

module fixed_point_lane_dot #(
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC_BITS = 14,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC_BITS = 14,
    parameter int P_FRAC_BITS = 14,
    parameter int N           = 3,
    parameter int LANES       = 1,
    localparam int EXTRA_FRAC_BITS = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS,
    localparam int P_WIDTH         = A_WIDTH + B_WIDTH - EXTRA_FRAC_BITS,
    localparam int ACC_WIDTH       = A_WIDTH + B_WIDTH + $clog2(N + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [N-1:0][A_WIDTH-1:0]     A,
    input  logic [N-1:0][B_WIDTH-1:0]     B,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [P_WIDTH-1:0]            P,
    output logic                          busy
);
    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam int K      = (N + LANES - 1) / LANES;
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                      state;
    logic [IDX_W-1:0]                idx;
    logic signed [ACC_WIDTH-1:0]     acc;
    logic signed [ACC_WIDTH-1:0]     chunk_sum;
    logic signed [ACC_WIDTH-1:0]     acc_next;
    logic [N-1:0][A_WIDTH-1:0]       a_reg;
    logic [N-1:0][B_WIDTH-1:0]       b_reg;
    logic [K*LANES-1:0][A_WIDTH-1:0] a_pad;
    logic [K*LANES-1:0][B_WIDTH-1:0] b_pad;
    logic [LANES-1:0][PROD_W-1:0]    prods;
    logic [P_WIDTH-1:0]              p_next;
    logic [P_WIDTH-1:0]              p_reg;
    logic                            valid_reg;

    // Zero-pad the latched operands so the last chunk reads zeros past element N-1.
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[N-1:0] = a_reg;
        b_pad[N-1:0] = b_reg;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [A_WIDTH-1:0] a_sel;
        logic [B_WIDTH-1:0] b_sel;

        always_comb begin
            a_sel = '0;
            b_sel = '0;
            for (int k = 0; k < K; k++) begin
                if (idx == IDX_W'(k)) begin
                    a_sel = a_pad[k*LANES + l];
                    b_sel = b_pad[k*LANES + l];
                end
            end
        end

        fixed_point_lane_dot_lane #(
            .A_WIDTH(A_WIDTH),
            .B_WIDTH(B_WIDTH)
        ) u_lane (
            .en  (state == ACCUM),
            .a   (a_sel),
            .b   (b_sel),
            .prod(prods[l])
        );
    end

    always_comb begin
        chunk_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            chunk_sum = chunk_sum + ACC_WIDTH'($signed(prods[l]));
        end
    end

    assign acc_next = acc + chunk_sum;

`ifdef FIXED_POINT_LANE_DOT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] P_MAX =
        {{(ACC_WIDTH-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] P_MIN =
        {{(ACC_WIDTH-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] shifted;

    assign shifted = acc_next >>> EXTRA_FRAC_BITS;

    always_comb begin
        if (shifted > P_MAX)      p_next = P_MAX[P_WIDTH-1:0];
        else if (shifted < P_MIN) p_next = P_MIN[P_WIDTH-1:0];
        else                      p_next = shifted[P_WIDTH-1:0];
    end
`else
    // Out-of-range results wrap: keep the low P_WIDTH bits of the shifted sum.
    assign p_next = P_WIDTH'(acc_next >>> EXTRA_FRAC_BITS);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        a_reg <= A;
                        b_reg <= B;
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    if (idx == IDX_W'(K - 1)) begin
                        p_reg     <= p_next;
                        valid_reg <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_out = (state == IDLE);
    assign busy      = (state != IDLE);
    assign valid_out = valid_reg;
    assign P         = p_reg;
endmodule

// File: tb/tb_fixed_point_lane_dot.sv
// Self-checking bench for fixed_point_lane_dot: default build plus LANES=2 and N=5 variants.
module tb_fixed_point_lane_dot;
    logic             clk = 1'b0;
    logic             rst_in;
    logic [2:0][15:0] A, B;
    logic             valid_in, ready_in;
    logic             ready_out, valid_out, busy;
    logic [17:0]      P;
    logic             ready_out2, valid_out2, busy2;
    logic [17:0]      P2;
    logic [4:0][15:0] A5, B5;
    logic             valid5;
    logic             ready_out5, valid_out5, busy5;
    logic [17:0]      P5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_point_lane_dot dut (
        .clk_in(clk), .rst_in(rst_in), .A(A), .B(B), .valid_in(valid_in),
        .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in), .P(P), .busy(busy)
    );

    fixed_point_lane_dot #(.LANES(2)) dut_l2 (
        .clk_in(clk), .rst_in(rst_in), .A(A), .B(B), .valid_in(valid_in),
        .ready_out(ready_out2), .valid_out(valid_out2), .ready_in(ready_in), .P(P2), .busy(busy2)
    );

    fixed_point_lane_dot #(.N(5), .LANES(2)) dut5 (
        .clk_in(clk), .rst_in(rst_in), .A(A5), .B(B5), .valid_in(valid5),
        .ready_out(ready_out5), .valid_out(valid_out5), .ready_in(ready_in), .P(P5), .busy(busy5)
    );

    // Reference: exact real-valued sum in Q28, rescaled to Q14 and reduced to 18 bits.
    function automatic logic [17:0] scale(input longint s);
        longint sh = s >>> 14;
`ifdef FIXED_POINT_LANE_DOT_SAT_EN
        if (sh > 131071) sh = 131071;
        else if (sh < -131072) sh = -131072;
`endif
        return sh[17:0];
    endfunction

    function automatic logic [17:0] model3(input logic [2:0][15:0] a, input logic [2:0][15:0] b);
        longint s = 0;
        for (int i = 0; i < 3; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
        return scale(s);
    endfunction

    function automatic logic [15:0] rnd16();
        return ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
    endfunction

    task automatic issue(input logic [2:0][15:0] a, input logic [2:0][15:0] b);
        A = a; B = b; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid_out !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (valid_out !== 1'b1) begin
            failures++;
            $display("FAIL wait_valid: valid_out=%b after %0d cycles, required 1", valid_out, lat);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid_out, ready_out, busy} !== 3'b010) begin
            failures++; $display("FAIL reset_ctrl: v/r/b=%b required 010", {valid_out, ready_out, busy});
        end
        checks++;
        if (P !== 18'd0) begin failures++; $display("FAIL reset_P: got %0d required 0", P); end
        checks++;
        if ({valid_out2, ready_out2, busy2} !== 3'b010) begin
            failures++; $display("FAIL reset_l2: v/r/b=%b required 010", {valid_out2, ready_out2, busy2});
        end
        checks++;
        if ({valid_out5, ready_out5, busy5, P5} !== {3'b010, 18'd0}) begin
            failures++; $display("FAIL reset_n5: v/r/b=%b P=%0d required 010 P=0",
                                 {valid_out5, ready_out5, busy5}, P5);
        end
        rst_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [17:0] p2;
        int lat = 1, lat2 = 0;
        ready_in = 1'b1;
        issue({16'hF000, 16'd8192, 16'd16384}, {16'd16384, 16'd16384, 16'd16384});
        while (lat < 40) begin
            if (valid_out2 === 1'b1 && lat2 == 0) begin lat2 = lat; p2 = P2; end
            if (valid_out === 1'b1) break;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL basic_latency: got %0d required 4", lat); end
        checks++;
        if (P !== 18'd20480) begin failures++; $display("FAIL basic_P: got %0d required 20480", P); end
        checks++;
        if (lat2 != 3) begin failures++; $display("FAIL lanes2_latency: got %0d required 3", lat2); end
        checks++;
        if (p2 !== 18'd20480) begin failures++; $display("FAIL lanes2_P: got %0d required 20480", p2); end
        @(negedge clk);
        checks++;
        if ({valid_out, ready_out} !== 2'b01) begin
            failures++; $display("FAIL basic_pulse: valid/ready=%b required 01", {valid_out, ready_out});
        end
    endtask

    task automatic test_n5();
        int lat = 1;
        longint s;
        logic [17:0] exp5;
        for (int t = 0; t < 4; t++) begin
            s = 0;
            for (int i = 0; i < 5; i++) begin
                A5[i] = (t == 0) ? 16'd16384 : rnd16();
                B5[i] = (t == 0) ? 16'd16384 : rnd16();
                s += longint'($signed(A5[i])) * longint'($signed(B5[i]));
            end
            exp5 = (t == 0) ? 18'd81920 : scale(s);
            valid5 = 1'b1;
            @(negedge clk);
            valid5 = 1'b0;
            lat = 1;
            while (valid_out5 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
            checks++;
            if (lat != 4) begin failures++; $display("FAIL n5_latency[%0d]: got %0d required 4", t, lat); end
            checks++;
            if (P5 !== exp5) begin failures++; $display("FAIL n5_P[%0d]: got %0d required %0d", t, P5, exp5); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [2:0][15:0] a = {16'd100, 16'hFF00, 16'd30000};
        logic [2:0][15:0] b = {16'd2000, 16'd16384, 16'hC000};
        logic [17:0] exp = model3(a, b);
        ready_in = 1'b0;
        issue(a, b);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin A = '0; B = '0; valid_in = 1'b1; end
            if (c == 2) valid_in = 1'b0;
            checks++;
            if ({valid_out, ready_out, busy} !== 3'b101 || P !== exp) begin
                failures++;
                $display("FAIL bp_hold[%0d]: v/r/b=%b P=%0d required 101 P=%0d",
                         c, {valid_out, ready_out, busy}, P, exp);
            end
            @(negedge clk);
        end
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_out, ready_out, busy} !== 3'b010 || P !== exp) begin
            failures++;
            $display("FAIL bp_release: v/r/b=%b P=%0d required 010 P=%0d", {valid_out, ready_out, busy}, P, exp);
        end
    endtask

    task automatic test_capture();
        int lat;
        logic [2:0][15:0] a = {16'd5000, 16'hE000, 16'd12345};
        logic [2:0][15:0] b = {16'd16384, 16'd7000, 16'hF123};
        logic [17:0] exp = model3(a, b);
        issue(a, b);
        A = '0; B = '0;
        wait_valid(lat);
        checks++;
        if (P !== exp) begin failures++; $display("FAIL capture_P: got %0d required %0d", P, exp); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lat;
        logic [17:0] exp;
`ifdef FIXED_POINT_LANE_DOT_SAT_EN
        exp = 18'd131071;
`else
        exp = 18'h30000;
`endif
        issue({3{16'h8000}}, {3{16'h8000}});
        wait_valid(lat);
        checks++;
        if (P !== exp) begin failures++; $display("FAIL overflow_pos: got %0d required %0d", P, exp); end
        @(negedge clk);
        issue({3{16'h8000}}, {3{16'h7FFF}});
        wait_valid(lat);
        checks++;
        if (P !== model3({3{16'h8000}}, {3{16'h7FFF}})) begin
            failures++; $display("FAIL overflow_neg: got %0d required %0d", P, model3({3{16'h8000}}, {3{16'h7FFF}}));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2:0][15:0] a = {16'd1234, 16'd4321, 16'hFFFF};
        logic [2:0][15:0] b = {16'h9000, 16'd3, 16'd16384};
        issue({3{16'd16384}}, {3{16'd16384}});
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        checks++;
        if ({valid_out, ready_out, busy} !== 3'b010 || P !== 18'd0) begin
            failures++;
            $display("FAIL mid_reset: v/r/b=%b P=%0d required 010 P=0", {valid_out, ready_out, busy}, P);
        end
        issue(a, b);
        wait_valid(lat);
        checks++;
        if (P !== model3(a, b)) begin
            failures++; $display("FAIL after_reset_P: got %0d required %0d", P, model3(a, b));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, d;
        logic [2:0][15:0] a, b;
        logic [17:0] exp;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 3; i++) begin a[i] = rnd16(); b[i] = rnd16(); end
            exp = model3(a, b);
            d = $urandom_range(0, 3);
            ready_in = (d == 0);
            issue(a, b);
            wait_valid(lat);
            checks++;
            if (lat != 4 || P !== exp) begin
                failures++; $display("FAIL rand[%0d]: lat=%0d P=%0d required lat=4 P=%0d", t, lat, P, exp);
            end
            repeat (d) @(negedge clk);
            ready_in = 1'b1;
            @(negedge clk);
            checks++;
            if ({valid_out, ready_out} !== 2'b01 || P !== exp) begin
                failures++;
                $display("FAIL rand_done[%0d]: v/r=%b P=%0d required 01 P=%0d", t, {valid_out, ready_out}, P, exp);
            end
        end
    endtask

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; valid5 = 1'b0;
        A = '0; B = '0; A5 = '0; B5 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_n5();
        test_back_pressure();
        test_capture();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
